// File: rtl/rng_scheduler.sv
// Round-robin arbiter and reseed sequencer for the shared 8-bit LFSR; serves bounded draws by masked rejection sampling.
// Optional lock-up detection (stuck port) is compiled in with `define RNG_SCHED_STUCK_DET_EN.
module rng_scheduler #(
  parameter int         N_REQ     = 4,
  parameter logic [7:0] SEED_INIT = 8'hA5,
  parameter int         MAX_DRAWS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rand_in,
  output logic                 lfsr_rst,
  output logic [7:0]           lfsr_seed,
  input  logic [7:0]           seed,
  input  logic                 seed_load,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   limit,
  output logic [N_REQ-1:0]     gnt,
  output logic [7:0]           value,
  output logic                 valid,
  output logic                 busy
`ifdef RNG_SCHED_STUCK_DET_EN
  ,
  output logic                 stuck
`endif
);

  localparam int         IW        = $clog2(N_REQ);
  localparam logic [3:0] LAST_DRAW = 4'(MAX_DRAWS - 1);

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_IDLE = 2'd1,
    ST_DRAW = 2'd2
  } state_t;

  // Smallest 2^k-1 covering lim, by smearing the top set bit downwards.
  function automatic logic [7:0] mask_of(input logic [7:0] lim);
    logic [7:0] m;
    m = lim | (lim >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

  // An all-zero seed would lock the LFSR, so substitute all-ones.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'hFF : s;
  endfunction

  // Returns {found, index} of the first request at or after ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end else begin
        j = j;
      end
      if (r[j]) begin
        res = {1'b1, IW'(j)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t             state_q, state_d;
  logic               lfsr_rst_q, lfsr_rst_d;
  logic [7:0]         lfsr_seed_q, lfsr_seed_d;
  logic               seed_pend_q, seed_pend_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [7:0]         lim_q, lim_d;
  logic [7:0]         mask_q, mask_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]         value_q, value_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [7:0]         cand;
  logic [IW:0]        pick;
  logic               accept;
  logic [7:0]         acc_val;
`ifdef RNG_SCHED_STUCK_DET_EN
  logic               stuck_q, stuck_d;
  logic               zero_prev_q, zero_prev_d;
  logic               zero_now;
`endif

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state_q;
    lfsr_rst_d  = 1'b0;
    lfsr_seed_d = lfsr_seed_q;
    seed_pend_d = seed_pend_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    lim_d       = lim_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    value_d     = value_q;
    valid_d     = 1'b0;
    accept      = 1'b0;
    acc_val     = 8'h00;
    cand        = rand_in & mask_q;
    pick        = rr_pick(req, rr_q);

    if (seed_load) begin
      lfsr_seed_d = fix_seed(seed);
      seed_pend_d = 1'b1;
    end else begin
      lfsr_seed_d = lfsr_seed_q;
    end

    case (state_q)
      ST_SEED: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (seed_pend_q || seed_load) begin
          state_d     = ST_SEED;
          lfsr_rst_d  = 1'b1;
          seed_pend_d = 1'b0;
        end else if (pick[IW]) begin
          owner_d = pick[IW-1:0];
          lim_d   = limit[{pick[IW-1:0], 3'b000} +: 8];
          mask_d  = mask_of(limit[{pick[IW-1:0], 3'b000} +: 8]);
          cnt_d   = 4'd0;
          state_d = ST_DRAW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (cand <= lim_q) begin
          accept  = 1'b1;
          acc_val = cand;
        end else if (cnt_q == LAST_DRAW) begin
          // Halving a rejected masked value always lands within lim.
          accept  = 1'b1;
          acc_val = cand >> 1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d    = ST_SEED;
        lfsr_rst_d = 1'b1;
      end
    endcase

    if (accept) begin
      value_d = acc_val;
      valid_d = 1'b1;
      gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
      rr_d    = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
      state_d = ST_IDLE;
    end else begin
      value_d = value_q;
    end

`ifdef RNG_SCHED_STUCK_DET_EN
    zero_now    = (state_q != ST_SEED) && (rand_in == 8'h00);
    zero_prev_d = zero_now;
    stuck_d     = stuck_q;
    // Lock-up pre-empts everything; a software seed arriving now is dropped.
    if (zero_now && zero_prev_q) begin
      stuck_d     = 1'b1;
      lfsr_seed_d = SEED_INIT;
      seed_pend_d = 1'b0;
      state_d     = ST_SEED;
      lfsr_rst_d  = 1'b1;
      gnt_d       = '0;
      valid_d     = 1'b0;
      value_d     = value_q;
      rr_d        = rr_q;
    end else begin
      stuck_d = stuck_q;
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEED;
      lfsr_rst_q  <= 1'b1;
      lfsr_seed_q <= SEED_INIT;
      seed_pend_q <= 1'b0;
      rr_q        <= '0;
      owner_q     <= '0;
      lim_q       <= 8'h00;
      mask_q      <= 8'h00;
      cnt_q       <= 4'd0;
      gnt_q       <= '0;
      value_q     <= 8'h00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b1;
`ifdef RNG_SCHED_STUCK_DET_EN
      stuck_q     <= 1'b0;
      zero_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_rst_q  <= lfsr_rst_d;
      lfsr_seed_q <= lfsr_seed_d;
      seed_pend_q <= seed_pend_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      lim_q       <= lim_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
`ifdef RNG_SCHED_STUCK_DET_EN
      stuck_q     <= stuck_d;
      zero_prev_q <= zero_prev_d;
`endif
    end
  end

  assign lfsr_rst  = lfsr_rst_q;
  assign lfsr_seed = lfsr_seed_q;
  assign gnt       = gnt_q;
  assign value     = value_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
`ifdef RNG_SCHED_STUCK_DET_EN
  assign stuck     = stuck_q;
`endif

endmodule

// File: tb/tb_rng_scheduler.sv
// Directed, table-driven bench for rng_scheduler (N_REQ=4, MAX_DRAWS=8, SEED_INIT=8'hA5).
module tb_rng_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rand_in = 8'h11;
  logic        lfsr_rst;
  logic [7:0]  lfsr_seed;
  logic [7:0]  seed = 8'h00;
  logic        seed_load = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] limit = 32'hFFFF_FFFF;
  logic [3:0]  gnt;
  logic [7:0]  value;
  logic        valid;
  logic        busy;
`ifdef RNG_SCHED_STUCK_DET_EN
  logic        stuck;
`endif

  int checks = 0;
  int failures = 0;

  rng_scheduler #(.N_REQ(4), .SEED_INIT(8'hA5), .MAX_DRAWS(8)) dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .lfsr_rst(lfsr_rst), .lfsr_seed(lfsr_seed),
    .seed(seed), .seed_load(seed_load), .req(req), .limit(limit), .gnt(gnt),
    .value(value), .valid(valid), .busy(busy)
`ifdef RNG_SCHED_STUCK_DET_EN
    , .stuck(stuck)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] lim;
    logic [7:0] rnd;
    logic [7:0] exp_val;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Grant at the first tick, then count edges until valid (bounded).
  task automatic run_draw(input int n, input int idx, input logic [7:0] lim, input logic [7:0] rnd,
                          input logic [7:0] exp_val, input int exp_cyc);
    int cnt;
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    limit[8*idx +: 8] = lim;
    rand_in = rnd;
    req = onehot;
    tick();
    check($sformatf("vec%0d_busy", n), {31'd0, busy}, 32'd1);
    check($sformatf("vec%0d_novalid", n), {31'd0, valid}, 32'd0);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!valid && cnt < 20);
    req = 4'b0000;
    check($sformatf("vec%0d_valid", n), {31'd0, valid}, 32'd1);
    check($sformatf("vec%0d_cycles", n), cnt, exp_cyc);
    check($sformatf("vec%0d_value", n), {24'd0, value}, {24'd0, exp_val});
    check($sformatf("vec%0d_gnt", n), {28'd0, gnt}, {28'd0, onehot});
  endtask

  initial begin
    int cnt;
    int ng;
    int last_edge;
    logic [3:0] rr_exp[4];

    vecs[0] = '{2, 8'h0F, 8'h37, 8'h07, 1};
    vecs[1] = '{0, 8'h09, 8'hFE, 8'h07, 8};
    vecs[2] = '{1, 8'h00, 8'hC3, 8'h00, 1};
    vecs[3] = '{3, 8'hFF, 8'h5A, 8'h5A, 1};
    vecs[4] = '{2, 8'h64, 8'hE9, 8'h34, 8};
    vecs[5] = '{1, 8'h80, 8'h80, 8'h80, 1};
    vecs[6] = '{0, 8'h05, 8'h0D, 8'h05, 1};
    vecs[7] = '{3, 8'h01, 8'h02, 8'h00, 1};
    vecs[8] = '{0, 8'h06, 8'h07, 8'h03, 8};
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_lfsr_rst", {31'd0, lfsr_rst}, 32'd1);
    check("rst_seed", {24'd0, lfsr_seed}, 32'hA5);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_value", {24'd0, value}, 32'd0);
    rst = 1'b0;
    #2;
    check("seed_pulse_hi", {31'd0, lfsr_rst}, 32'd1);
    tick();
    check("seed_pulse_lo", {31'd0, lfsr_rst}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_seed", {24'd0, lfsr_seed}, 32'hA5);

    for (int i = 0; i < 9; i++) begin
      run_draw(i, vecs[i].idx, vecs[i].lim, vecs[i].rnd, vecs[i].exp_val, vecs[i].exp_cyc);
    end

    // Owner drops req and changes its limit mid-draw: latched limit still used
    limit[23:16] = 8'h09;
    rand_in = 8'hFE;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    limit[23:16] = 8'hFF;
    tick();
    check("drop_rej1", {31'd0, valid}, 32'd0);
    tick();
    check("drop_rej2", {31'd0, valid}, 32'd0);
    rand_in = 8'h35;
    tick();
    check("drop_valid", {31'd0, valid}, 32'd1);
    check("drop_value", {24'd0, value}, 32'h05);
    check("drop_gnt", {28'd0, gnt}, 32'h4);

    // seed_load in IDLE
    seed = 8'h3C;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("ld_idle_rst", {31'd0, lfsr_rst}, 32'd1);
    check("ld_idle_seed", {24'd0, lfsr_seed}, 32'h3C);
    check("ld_idle_busy", {31'd0, busy}, 32'd1);
    tick();
    check("ld_idle_rst_lo", {31'd0, lfsr_rst}, 32'd0);
    check("ld_idle_busy_lo", {31'd0, busy}, 32'd0);

    // Zero seed during DRAW: draw finishes, reseed with FF before next grant
    limit[7:0] = 8'h09;
    limit[15:8] = 8'hFF;
    rand_in = 8'hFE;
    req = 4'b0001;
    tick();
    seed = 8'h00;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("sd_seed_ff", {24'd0, lfsr_seed}, 32'hFF);
    check("sd_no_rst", {31'd0, lfsr_rst}, 32'd0);
    req = 4'b0011;
    cnt = 1;
    while (!valid && cnt < 20) begin
      tick();
      cnt++;
    end
    req = 4'b0010;
    check("sd_cycles", cnt, 8);
    check("sd_value", {24'd0, value}, 32'h07);
    check("sd_gnt", {28'd0, gnt}, 32'h1);
    tick();
    check("sd_rst_hi", {31'd0, lfsr_rst}, 32'd1);
    check("sd_no_gnt", {28'd0, gnt}, 32'h0);
    tick();
    check("sd_rst_lo", {31'd0, lfsr_rst}, 32'd0);
    check("sd_idle", {31'd0, busy}, 32'd0);
    tick();
    check("sd_regrant", {31'd0, busy}, 32'd1);
    tick();
    check("sd2_value", {24'd0, value}, 32'hFE);
    check("sd2_gnt", {28'd0, gnt}, 32'h2);
    req = 4'b0000;

    // rst mid-draw abandons the draw and the pending seed
    rand_in = 8'hFE;
    req = 4'b0001;
    tick();
    seed = 8'h44;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req = 4'b0000;
    rst = 1'b1;
    #1;
    check("mid_rst_lfsr", {31'd0, lfsr_rst}, 32'd1);
    check("mid_rst_seed", {24'd0, lfsr_seed}, 32'hA5);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    check("mid_rst_value", {24'd0, value}, 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_idle", {31'd0, busy}, 32'd0);
    tick();
    check("mid_rst_nopend", {31'd0, lfsr_rst}, 32'd0);
    check("mid_rst_nopend_busy", {31'd0, busy}, 32'd0);

    // Round robin from pointer 0 with req held
    limit = 32'hFFFF_FFFF;
    rand_in = 8'h11;
    req = 4'b1011;
    ng = 0;
    last_edge = 0;
    for (int e = 1; e <= 20 && ng < 4; e++) begin
      tick();
      if (valid) begin
        check($sformatf("rr_gnt%0d", ng), {28'd0, gnt}, {28'd0, rr_exp[ng]});
        if (ng > 0) begin
          check($sformatf("rr_period%0d", ng), e - last_edge, 2);
        end
        last_edge = e;
        ng++;
      end
    end
    req = 4'b0000;
    check("rr_count", ng, 4);
    tick();

`ifdef RNG_SCHED_STUCK_DET_EN
    // Lock-up: zero in grant cycle and first DRAW cycle
    rand_in = 8'h00;
    req = 4'b0001;
    tick();
    check("lk_grant", {31'd0, busy}, 32'd1);
    check("lk_stuck0", {31'd0, stuck}, 32'd0);
    tick();
    rand_in = 8'h5A;
    check("lk_stuck", {31'd0, stuck}, 32'd1);
    check("lk_no_valid", {31'd0, valid}, 32'd0);
    check("lk_no_gnt", {28'd0, gnt}, 32'd0);
    check("lk_rst", {31'd0, lfsr_rst}, 32'd1);
    check("lk_seed", {24'd0, lfsr_seed}, 32'hA5);
    tick();
    check("lk_rst_lo", {31'd0, lfsr_rst}, 32'd0);
    tick();
    check("lk_regrant", {31'd0, busy}, 32'd1);
    tick();
    check("lk_value", {24'd0, value}, 32'h5A);
    check("lk_gnt", {28'd0, gnt}, 32'h1);
    check("lk_sticky", {31'd0, stuck}, 32'd1);
    req = 4'b0000;
`else
    // Without detection a zero LFSR just yields value 0
    run_draw(20, 0, 8'h0F, 8'h00, 8'h00, 1);
    run_draw(21, 1, 8'hFF, 8'h00, 8'h00, 1);
    check("zero_no_reseed", {31'd0, lfsr_rst}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
